// File: rtl/vend_pkg.sv
// Shared constants for the vending panel arbiter: coin values, button codes, prices, FSM states.
// Also holds the pure event-legality and vend-start helpers used at accept time.
package vend_pkg;

    localparam logic [15:0] COIN_10  = 16'd10;
    localparam logic [15:0] COIN_20  = 16'd20;
    localparam logic [15:0] COIN_50  = 16'd50;
    localparam logic [15:0] COIN_100 = 16'd100;
    localparam logic [15:0] COIN_200 = 16'd200;

    localparam logic [1:0] BTN_NONE  = 2'b00;
    localparam logic [1:0] BTN_WATER = 2'b01;
    localparam logic [1:0] BTN_SODA  = 2'b11;

    localparam logic [15:0] WATER_PRICE = 16'd30;
    localparam logic [15:0] SODA_PRICE  = 16'd50;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_FWD  = 2'd2,
        ARB_VEND = 2'd3
    } arb_state_e;

    // A coin alone, or a drink button alone; anything else is dropped.
    function automatic logic ev_is_legal(input logic [15:0] coin, input logic [1:0] btn);
        logic coin_ok;
        coin_ok = (coin == COIN_10) || (coin == COIN_20) || (coin == COIN_50) ||
                  (coin == COIN_100) || (coin == COIN_200);
        if (btn == BTN_NONE) begin
            return coin_ok;
        end
        return ((btn == BTN_WATER) || (btn == BTN_SODA)) && (coin == 16'd0);
    endfunction

    function automatic logic ev_starts_vend(input logic [1:0] btn, input logic [15:0] credit);
        return ((btn == BTN_WATER) && (credit >= WATER_PRICE)) ||
               ((btn == BTN_SODA)  && (credit >= SODA_PRICE));
    endfunction

endpackage

// File: rtl/rr_picker.sv
// N-way round-robin one-hot selector: search starts one position past the one-hot 'last'.
// Purely combinational.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] pick
);

    int   last_idx;
    logic found;

    always_comb begin
        pick     = '0;
        last_idx = 0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (last[i]) begin
                last_idx = i;
            end
        end
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == ((last_idx + k) % N))) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vend_panel_arbiter.sv
// Grants one panel exclusive use of the vending core per purchase session; forwards one event per 2 cycles.
// Optional idle-ownership timeout is compiled in with VEND_ARB_TIMEOUT_EN.
module vend_panel_arbiter
    import vend_pkg::*;
#(
    parameter int N_PANELS    = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_PANELS-1:0]     req_valid,
    input  logic [16*N_PANELS-1:0]  req_coin,
    input  logic [2*N_PANELS-1:0]   req_button,
    output logic [N_PANELS-1:0]     req_ready,
    output logic [N_PANELS-1:0]     req_reject,
    output logic [N_PANELS-1:0]     grant,
    output logic [15:0]             core_coin,
    output logic [1:0]              core_button,
    input  logic                    core_idle,
    input  logic [15:0]             core_credit,
    input  logic [1:0]              core_beverage
);

    // Resetting 'last' to the top panel makes panel 0 the first winner.
    localparam logic [N_PANELS-1:0] LAST_RST = {1'b1, {(N_PANELS-1){1'b0}}};

    arb_state_e          state_q;
    logic [N_PANELS-1:0] grant_q;
    logic [N_PANELS-1:0] last_q;
    logic [N_PANELS-1:0] reject_q;
    logic [15:0]         coin_q;
    logic [1:0]          btn_q;
    logic                vend_q;
    logic                seen_q;

    logic [15:0]         own_coin;
    logic [1:0]          own_btn;
    logic                own_vld;
    logic                accept;
    logic                ev_legal;
    logic                ev_vend;
    logic [N_PANELS-1:0] pick;
    logic                tmo_hit;

    rr_picker #(.N(N_PANELS)) u_rr_picker (
        .req  (req_valid),
        .last (last_q),
        .pick (pick)
    );

    always_comb begin
        own_coin = '0;
        own_btn  = '0;
        for (int i = 0; i < N_PANELS; i++) begin
            if (grant_q[i]) begin
                own_coin = req_coin[16*i +: 16];
                own_btn  = req_button[2*i +: 2];
            end
        end
    end

    assign own_vld  = |(req_valid & grant_q);
    assign accept   = (state_q == ARB_OWN) && own_vld && core_idle;
    assign ev_legal = ev_is_legal(own_coin, own_btn);
    // Vend decision uses the credit seen at accept, before the core adds anything.
    assign ev_vend  = ev_legal && ev_starts_vend(own_btn, core_credit);

`ifdef VEND_ARB_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] tmo_q;

    assign tmo_hit = (state_q == ARB_OWN) && !accept && (core_credit == 16'd0) && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if ((state_q != ARB_OWN) || accept || (core_credit != 16'd0) || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 32'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            last_q   <= LAST_RST;
            reject_q <= '0;
            coin_q   <= '0;
            btn_q    <= '0;
            vend_q   <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            reject_q <= '0;
            coin_q   <= '0;
            btn_q    <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (|req_valid) begin
                        grant_q <= pick;
                        state_q <= ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (accept) begin
                        if (ev_legal) begin
                            coin_q <= own_coin;
                            btn_q  <= own_btn;
                        end else begin
                            reject_q <= grant_q;
                        end
                        vend_q  <= ev_vend;
                        state_q <= ARB_FWD;
                    end else if (tmo_hit) begin
                        last_q  <= grant_q;
                        grant_q <= '0;
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_FWD: begin
                    seen_q  <= 1'b0;
                    state_q <= vend_q ? ARB_VEND : ARB_OWN;
                end
                ARB_VEND: begin
                    if (core_beverage != 2'b00) begin
                        seen_q <= 1'b1;
                    end
                    if (seen_q && core_idle) begin
                        if (core_credit == 16'd0) begin
                            last_q  <= grant_q;
                            grant_q <= '0;
                            state_q <= ARB_IDLE;
                        end else begin
                            state_q <= ARB_OWN;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign req_ready   = accept ? grant_q : '0;
    assign req_reject  = reject_q;
    assign grant       = grant_q;
    assign core_coin   = coin_q;
    assign core_button = btn_q;

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Directed bench for vend_panel_arbiter: event table for the owner panel plus hand-written session sequences.
module tb_vend_panel_arbiter;
    import vend_pkg::*;

    localparam int N = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [16*N-1:0] req_coin;
    logic [2*N-1:0]  req_button;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_reject;
    logic [N-1:0]    grant;
    logic [15:0]     core_coin;
    logic [1:0]      core_button;
    logic            core_idle;
    logic [15:0]     core_credit;
    logic [1:0]      core_beverage;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] coin;
        logic [1:0]  btn;
        logic [15:0] credit;
        logic [15:0] e_coin;
        logic [1:0]  e_btn;
        logic        e_rej;
        logic        e_vend;
    } vec_t;

    vec_t vecs [16];

    vend_panel_arbiter #(.N_PANELS(N), .TIMEOUT_CYC(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_coin      (req_coin),
        .req_button    (req_button),
        .req_ready     (req_ready),
        .req_reject    (req_reject),
        .grant         (grant),
        .core_coin     (core_coin),
        .core_button   (core_button),
        .core_idle     (core_idle),
        .core_credit   (core_credit),
        .core_beverage (core_beverage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Presents one event for panel p in an ARB_OWN cycle, checks the accept and the forward cycle.
    // Returns positioned inside the ARB_FWD cycle.
    task automatic send_event(input int p, input logic [15:0] coin, input logic [1:0] btn,
                              input logic [15:0] credit, input logic [15:0] e_coin,
                              input logic [1:0] e_btn, input logic e_rej);
        logic [N-1:0] pm;
        pm = '0;
        pm[p] = 1'b1;
        req_valid[p] = 1'b1;
        req_coin[16*p +: 16] = coin;
        req_button[2*p +: 2] = btn;
        core_credit = credit;
        core_idle = 1'b1;
        #1;
        chk("accept_ready", 32'(req_ready), 32'(pm));
        step();
        req_valid[p] = 1'b0;
        #1;
        chk("fwd_coin", 32'(core_coin), 32'(e_coin));
        chk("fwd_button", 32'(core_button), 32'(e_btn));
        chk("fwd_reject", 32'(req_reject), e_rej ? 32'(pm) : 32'd0);
        chk("fwd_ready", 32'(req_ready), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{16'd20,  BTN_NONE,  16'd20,  16'd20,  BTN_NONE,  1'b0, 1'b0};
        vecs[1]  = '{16'd30,  BTN_NONE,  16'd20,  16'd0,   BTN_NONE,  1'b1, 1'b0};
        vecs[2]  = '{16'd0,   BTN_SODA,  16'd20,  16'd0,   BTN_SODA,  1'b0, 1'b0};
        vecs[3]  = '{16'd0,   BTN_WATER, 16'd30,  16'd0,   BTN_WATER, 1'b0, 1'b1};
        vecs[4]  = '{16'd0,   BTN_WATER, 16'd29,  16'd0,   BTN_WATER, 1'b0, 1'b0};
        vecs[5]  = '{16'd0,   BTN_SODA,  16'd50,  16'd0,   BTN_SODA,  1'b0, 1'b1};
        vecs[6]  = '{16'd0,   BTN_SODA,  16'd49,  16'd0,   BTN_SODA,  1'b0, 1'b0};
        vecs[7]  = '{16'd0,   2'b10,     16'd100, 16'd0,   BTN_NONE,  1'b1, 1'b0};
        vecs[8]  = '{16'd10,  BTN_WATER, 16'd100, 16'd0,   BTN_NONE,  1'b1, 1'b0};
        vecs[9]  = '{16'd200, BTN_NONE,  16'd10,  16'd200, BTN_NONE,  1'b0, 1'b0};
        vecs[10] = '{16'd100, BTN_NONE,  16'd10,  16'd100, BTN_NONE,  1'b0, 1'b0};
        vecs[11] = '{16'd50,  BTN_NONE,  16'd10,  16'd50,  BTN_NONE,  1'b0, 1'b0};
        vecs[12] = '{16'd10,  BTN_NONE,  16'd10,  16'd10,  BTN_NONE,  1'b0, 1'b0};
        vecs[13] = '{16'd0,   BTN_NONE,  16'd10,  16'd0,   BTN_NONE,  1'b1, 1'b0};
        vecs[14] = '{16'd201, BTN_NONE,  16'd10,  16'd0,   BTN_NONE,  1'b1, 1'b0};
        vecs[15] = '{16'd0,   BTN_SODA,  16'd100, 16'd0,   BTN_SODA,  1'b0, 1'b1};

        rst = 1'b1;
        req_valid = '0;
        req_coin = '0;
        req_button = '0;
        core_idle = 1'b1;
        core_credit = '0;
        core_beverage = '0;
        #3;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_reject", 32'(req_reject), 32'd0);
        chk("rst_core_coin", 32'(core_coin), 32'd0);
        chk("rst_core_button", 32'(core_button), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Both panels request together: panel 0 wins first.
        req_valid = 2'b11;
        req_coin = {16'd10, 16'd20};
        #1;
        chk("idle_grant", 32'(grant), 32'd0);
        step();
        chk("first_grant", 32'(grant), 32'd1);
        send_event(0, 16'd20, BTN_NONE, 16'd0, 16'd20, BTN_NONE, 1'b0);
        step();

        // Event table; panel 1 stays pending throughout and must never be readied.
        for (int r = 0; r < 16; r++) begin
            send_event(0, vecs[r].coin, vecs[r].btn, vecs[r].credit,
                       vecs[r].e_coin, vecs[r].e_btn, vecs[r].e_rej);
            step();
            req_valid[0] = 1'b1;
            req_coin[15:0] = 16'd10;
            req_button[1:0] = BTN_NONE;
            #1;
            chk("post_fwd_ready", 32'(req_ready), vecs[r].e_vend ? 32'd0 : 32'd1);
            req_valid[0] = 1'b0;
            if (vecs[r].e_vend) begin
                core_idle = 1'b0;
                core_beverage = 2'b01;
                step();
                core_beverage = 2'b00;
                core_idle = 1'b1;
                core_credit = 16'd70;
                #1;
                chk("residual_grant", 32'(grant), 32'd1);
                chk("residual_ready", 32'(req_ready), 32'd0);
                step();
            end else begin
                step();
            end
        end

        // core_idle low stalls acceptance but keeps ownership.
        req_valid[0] = 1'b1;
        core_idle = 1'b0;
        #1;
        chk("stall_ready", 32'(req_ready), 32'd0);
        step();
        chk("stall_grant", 32'(grant), 32'd1);
        chk("stall_ready2", 32'(req_ready), 32'd0);
        req_valid[0] = 1'b0;
        core_idle = 1'b1;
        step();

        // Full water purchase: 20 + 20, water, change returned, release, panel 1 next.
        send_event(0, 16'd20, BTN_NONE, 16'd0, 16'd20, BTN_NONE, 1'b0);
        step();
        send_event(0, 16'd20, BTN_NONE, 16'd20, 16'd20, BTN_NONE, 1'b0);
        step();
        send_event(0, 16'd0, BTN_WATER, 16'd40, 16'd0, BTN_WATER, 1'b0);
        step();
        core_beverage = 2'b01;
        core_idle = 1'b0;
        core_credit = 16'd10;
        step();
        core_beverage = 2'b00;
        core_credit = 16'd0;
        #1;
        chk("vend_grant_b", 32'(grant), 32'd1);
        step();
        core_idle = 1'b1;
        req_valid = 2'b11;
        req_coin[31:16] = 16'd50;
        #1;
        chk("vend_grant_c", 32'(grant), 32'd1);
        chk("vend_ready_c", 32'(req_ready), 32'd0);
        step();
        chk("release_grant", 32'(grant), 32'd0);
        chk("release_ready", 32'(req_ready), 32'd0);
        step();
        chk("rr_grant", 32'(grant), 32'd2);
        send_event(1, 16'd50, BTN_NONE, 16'd0, 16'd50, BTN_NONE, 1'b0);

        // Reset in the forward cycle clears everything immediately.
        rst = 1'b1;
        #1;
        chk("arst_core_coin", 32'(core_coin), 32'd0);
        chk("arst_core_button", 32'(core_button), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_reject", 32'(req_reject), 32'd0);
        req_valid = '0;
        step();
        rst = 1'b0;
        step();

        // Idle ownership at zero credit; pointer is back at panel 0 after reset.
        req_valid = 2'b11;
        core_credit = 16'd0;
        step();
        req_valid = 2'b00;
        #1;
        chk("tmo_grant_start", 32'(grant), 32'd1);
        for (int k = 0; k < 7; k++) begin
            step();
        end
        chk("tmo_grant_8th", 32'(grant), 32'd1);
        step();
`ifdef VEND_ARB_TIMEOUT_EN
        chk("tmo_released", 32'(grant), 32'd0);
`else
        chk("no_tmo_held", 32'(grant), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
